// File: rtl/muldiv_sched.sv
// Sequencer for the EX-stage multiply/divide unit: captures an op's result into
// pending registers, counts out its latency, then commits it to HI/LO.
module muldiv_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_e,
    input  logic [31:0] rs_val_e,
    input  logic [31:0] rt_val_e,
    input  logic        md_use_d,
    output logic        start,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic        pend_dz, pend_dz_nxt;
    logic [31:0] hi_nxt, lo_nxt;

    logic        is_mul;
    logic [63:0] mul_a, mul_b, prod;
    logic        dvd_neg, dvs_neg, div_zero;
    logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quo, rem;

    assign start   = (op_e >= OP_MULT) && (op_e <= OP_DIVU);
    assign busy    = (state == RUN);
    assign stall_d = md_use_d & (start | busy);
    assign is_mul  = (op_e == OP_MULT) || (op_e == OP_MULTU);

    // Low 64 bits of the product are correct for both signednesses once the
    // operands are extended appropriately.
    always_comb begin
        mul_a = (op_e == OP_MULT) ? {{32{rs_val_e[31]}}, rs_val_e} : {32'd0, rs_val_e};
        mul_b = (op_e == OP_MULT) ? {{32{rt_val_e[31]}}, rt_val_e} : {32'd0, rt_val_e};
        prod  = mul_a * mul_b;
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        div_zero = (rt_val_e == 32'd0);
        dvd_neg  = (op_e == OP_DIV) && rs_val_e[31];
        dvs_neg  = (op_e == OP_DIV) && rt_val_e[31];
        dvd_mag  = dvd_neg ? (32'd0 - rs_val_e) : rs_val_e;
        dvs_mag  = dvs_neg ? (32'd0 - rt_val_e) : rt_val_e;
        dvs_safe = div_zero ? 32'd1 : dvs_mag;
        q_mag    = dvd_mag / dvs_safe;
        r_mag    = dvd_mag % dvs_safe;
        quo      = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = dvd_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
            hi_out  <= 32'd0;
            lo_out  <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_dz <= pend_dz_nxt;
            hi_out  <= hi_nxt;
            lo_out  <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_dz_nxt = pend_dz;
        hi_nxt      = hi_out;
        lo_nxt      = lo_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    if (is_mul) begin
                        pend_hi_nxt = prod[63:32];
                        pend_lo_nxt = prod[31:0];
                        pend_dz_nxt = 1'b0;
                        cnt_nxt     = MUL_CNT;
                    end else begin
                        pend_hi_nxt = rem;
                        pend_lo_nxt = quo;
                        pend_dz_nxt = div_zero;
                        cnt_nxt     = DIV_CNT;
                    end
                end else if (op_e == OP_MTHI) begin
                    hi_nxt = rs_val_e;
                end else if (op_e == OP_MTLO) begin
                    lo_nxt = rs_val_e;
                end
            end
            RUN: begin
                // op_e is ignored here; the hazard unit keeps it empty.
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                    if (!pend_dz) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, arithmetic, divide-by-zero,
// stall generation, async reset mid-op and protocol-violation handling.
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_e;
    logic [31:0] rs_val_e, rt_val_e;
    logic        md_use_d;
    logic        start, busy, stall_d;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op_e(op_e), .rs_val_e(rs_val_e),
        .rt_val_e(rt_val_e), .md_use_d(md_use_d), .start(start), .busy(busy),
        .stall_d(stall_d), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Present an op for one edge; returns at the negedge of the first busy cycle.
    task automatic drive_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        op_e = op; rs_val_e = rs; rt_val_e = rt;
        @(negedge clk);
        op_e = 4'd0;
    endtask

    // Counts busy cycles from the current negedge; bounded at 40.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_out, lo_out); end
        n_checks++; if (start !== 1'b0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL reset_start_stall got %0b/%0b want 0/0", start, stall_d); end
    endtask

    task automatic test_mult();
        int n;
        drive_op(4'd5, 32'h0000AAAA, 32'd0);
        n_checks++; if (hi_out !== 32'h0000AAAA || busy !== 1'b0) begin n_fail++; $display("FAIL mthi got hi=%h busy=%0b want 0000aaaa/0", hi_out, busy); end
        drive_op(4'd6, 32'h00005555, 32'd0);
        n_checks++; if (lo_out !== 32'h00005555) begin n_fail++; $display("FAIL mtlo got %h want 00005555", lo_out); end
        drive_op(4'd1, 32'hFFFFFFFD, 32'd5);
        n_checks++; if (busy !== 1'b1 || hi_out !== 32'h0000AAAA || lo_out !== 32'h00005555) begin
            n_fail++; $display("FAIL mult_hold got busy=%0b hi=%h lo=%h want 1/0000aaaa/00005555", busy, hi_out, lo_out); end
        count_busy(n);
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL mult_lat got %0d want 5", n); end
        n_checks++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_res got %h/%h want ffffffff/fffffff1", hi_out, lo_out); end
    endtask

    task automatic test_div();
        int n;
        drive_op(4'd3, 32'd7, 32'hFFFFFFFE);
        count_busy(n);
        n_checks++; if (n != 10) begin n_fail++; $display("FAIL div_lat got %0d want 10", n); end
        n_checks++; if (hi_out !== 32'd1 || lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_res got %h/%h want 00000001/fffffffd", hi_out, lo_out); end
        drive_op(4'd4, 32'd7, 32'd2);
        count_busy(n);
        n_checks++; if (hi_out !== 32'd1 || lo_out !== 32'd3) begin n_fail++; $display("FAIL divu_res got %h/%h want 00000001/00000003", hi_out, lo_out); end
        drive_op(4'd3, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        n_checks++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_negdvd got %h/%h want ffffffff/fffffffd", hi_out, lo_out); end
        drive_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        n_checks++; if (hi_out !== 32'd0 || lo_out !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf got %h/%h want 00000000/80000000", hi_out, lo_out); end
        drive_op(4'd2, 32'hFFFFFFFF, 32'd2);
        count_busy(n);
        n_checks++; if (hi_out !== 32'd1 || lo_out !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_res got %h/%h want 00000001/fffffffe", hi_out, lo_out); end
    endtask

    task automatic test_divzero();
        int n;
        drive_op(4'd5, 32'h00001234, 32'd0);
        drive_op(4'd4, 32'd99, 32'd0);
        count_busy(n);
        n_checks++; if (n != 10) begin n_fail++; $display("FAIL dz_lat got %0d want 10", n); end
        n_checks++; if (hi_out !== 32'h00001234 || lo_out !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL dz_hilo got %h/%h want 00001234/fffffffe", hi_out, lo_out); end
    endtask

    task automatic test_stall();
        int n, bad;
        @(negedge clk);
        md_use_d = 1'b1;
        op_e = 4'd1; rs_val_e = 32'd6; rt_val_e = 32'd7;
        #1;
        n_checks++; if (start !== 1'b1 || stall_d !== 1'b1) begin n_fail++; $display("FAIL stall_start got %0b/%0b want 1/1", start, stall_d); end
        @(negedge clk);
        op_e = 4'd0;
        n = 0; bad = 0;
        while (busy && n < 40) begin
            n++;
            if (stall_d !== 1'b1) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0 || n != 5) begin n_fail++; $display("FAIL stall_busy got bad=%0d lat=%0d want 0/5", bad, n); end
        n_checks++; if (stall_d !== 1'b0 || lo_out !== 32'd42 || hi_out !== 32'd0) begin
            n_fail++; $display("FAIL stall_release got stall=%0b lo=%h hi=%h want 0/0000002a/0", stall_d, lo_out, hi_out); end
        md_use_d = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_op(4'd5, 32'h00000099, 32'd0);
        drive_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            n_fail++; $display("FAIL rst_async got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi_out, lo_out); end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            n_fail++; $display("FAIL rst_nolate got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi_out, lo_out); end
    endtask

    task automatic test_violation();
        int n;
        drive_op(4'd1, 32'd100, 32'd3);
        n = 0;
        while (busy && n < 40) begin
            n++;
            op_e = (n == 2) ? 4'd3 : 4'd0;
            rs_val_e = 32'd7; rt_val_e = 32'd0;
            @(negedge clk);
        end
        op_e = 4'd0;
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL viol_lat got %0d want 5", n); end
        n_checks++; if (hi_out !== 32'd0 || lo_out !== 32'd300) begin n_fail++; $display("FAIL viol_res got %h/%h want 0/0000012c", hi_out, lo_out); end
        repeat (12) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || lo_out !== 32'd300) begin n_fail++; $display("FAIL viol_after got busy=%0b lo=%h want 0/0000012c", busy, lo_out); end
    endtask

    initial begin
        reset = 1'b1; op_e = 4'd0; rs_val_e = 32'd0; rt_val_e = 32'd0; md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_stall();
        test_reset_mid();
        test_violation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
